// File: rtl/rr_arbiter_if.sv
// Request/grant bundle between the requesting units and the round-robin arbiter
// that owns the shared comparator / priority-coder datapath.
//
// Handshake: di_req is a level request. A requester raises di_req[i] and keeps
// it high for as long as it wants the resource. It may use the resource in every
// cycle where do_gnt[i] is high. Dropping di_req[i] releases the grant at the
// next rising edge. A grant can also be withdrawn by the arbiter on timeout. In
// that case co_preempt pulses for one cycle, and the requester must keep di_req
// high if it wants the resource again.
`timescale 1ns/1ps
interface rr_arbiter_if #(
    parameter int LOGN = 2
);
    localparam int N = 1 << LOGN;

    logic [N-1:0]    di_req;
    logic [N-1:0]    do_gnt;
    logic [LOGN-1:0] do_gnt_id;
    logic            co_busy;
    logic            co_preempt;

    // Requester side: drives requests, observes the grant.
    modport master (
        output di_req,
        input  do_gnt,
        input  do_gnt_id,
        input  co_busy,
        input  co_preempt
    );

    // Arbiter side: samples requests, drives the registered grant.
    modport slave (
        input  di_req,
        output do_gnt,
        output do_gnt_id,
        output co_busy,
        output co_preempt
    );
endinterface

// File: rtl/rr_arbiter.sv
// Round-robin arbiter for 2**LOGN requesters sharing one datapath unit.
// - The one-hot grant is registered.
// - An owner keeps the grant while it holds its request.
// - With MAXHOLD > 0, an owner is preempted after MAXHOLD cycles if someone else is waiting.
// - Every ownership change passes through one IDLE cycle (bus turnaround).
`timescale 1ns/1ps
module rr_arbiter #(
    parameter int LOGN    = 2,
    parameter int MAXHOLD = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    rr_arbiter_if.slave     bus,
    output logic            dbg_state_o,   // 1 = BUSY, 0 = IDLE
    output logic [LOGN-1:0] dbg_ptr_o      // current round-robin pointer
);
    localparam int N         = 1 << LOGN;
    localparam int HW_RAW    = $clog2(MAXHOLD + 1);
    localparam int HW        = (HW_RAW < 1) ? 1 : HW_RAW;
    localparam int HOLD_LAST = (MAXHOLD > 0) ? (MAXHOLD - 1) : 0;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_t;

    state_t          state_q;
    logic [N-1:0]    gnt_q;
    logic [LOGN-1:0] gnt_id_q;
    logic [LOGN-1:0] ptr_q;
    logic [HW-1:0]   hold_q;
    logic            preempt_q;

    logic            found;
    logic [LOGN-1:0] win;
    logic [LOGN-1:0] idx;
    logic            waiting;

    localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD_LAST);

    // Pick the first requester at or after ptr, wrapping modulo N.
    always_comb begin
        found = 1'b0;
        win   = '0;
        idx   = '0;
        for (int k = 0; k < N; k++) begin
            idx = ptr_q + LOGN'(k);
            if (!found && bus.di_req[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
    end

    // Another requester is waiting while the current owner holds the grant.
    assign waiting = |(bus.di_req & ~gnt_q);

    // Grant FSM: arbitration, release, timeout preemption, and hold counting.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            gnt_q     <= '0;
            gnt_id_q  <= '0;
            ptr_q     <= '0;
            hold_q    <= '0;
            preempt_q <= 1'b0;
        end else begin
            preempt_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (found) begin
                        state_q  <= S_BUSY;
                        gnt_q    <= {{(N-1){1'b0}}, 1'b1} << win;
                        gnt_id_q <= win;
                        ptr_q    <= win + 1'b1;
                        hold_q   <= '0;
                    end
                end
                S_BUSY: begin
                    if (!bus.di_req[gnt_id_q]) begin
                        // Voluntary release wins over a coincident timeout.
                        state_q <= S_IDLE;
                        gnt_q   <= '0;
                    end else if ((MAXHOLD > 0) && (hold_q == HOLD_MAX) && waiting) begin
                        state_q   <= S_IDLE;
                        gnt_q     <= '0;
                        preempt_q <= 1'b1;
                    end else if (hold_q != HOLD_MAX) begin
                        hold_q <= hold_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    gnt_q   <= '0;
                end
            endcase
        end
    end

    assign bus.do_gnt     = gnt_q;
    assign bus.do_gnt_id  = gnt_id_q;
    assign bus.co_busy    = (state_q == S_BUSY);
    assign bus.co_preempt = preempt_q;
    assign dbg_state_o    = (state_q == S_BUSY);
    assign dbg_ptr_o      = ptr_q;
endmodule

// File: tb/tb_rr_arbiter.sv
// Directed bench for rr_arbiter.
// Three instances share clk/rst_n:
// - MAXHOLD=8: reset, rotation, single requester, wrap priority, async reset.
// - MAXHOLD=4: preemption and the no-contention case.
// - MAXHOLD=0: disabled limit.
`timescale 1ns/1ps
module tb_rr_arbiter;
    logic clk;
    logic rst_n;
    int   errors;
    int   checks;

    rr_arbiter_if #(.LOGN(2)) if8 ();
    rr_arbiter_if #(.LOGN(2)) if4 ();
    rr_arbiter_if #(.LOGN(2)) if0 ();

    logic       st8, st4, st0;
    logic [1:0] ptr8, ptr4, ptr0;

    rr_arbiter #(.LOGN(2), .MAXHOLD(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .bus(if8), .dbg_state_o(st8), .dbg_ptr_o(ptr8));
    rr_arbiter #(.LOGN(2), .MAXHOLD(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .bus(if4), .dbg_state_o(st4), .dbg_ptr_o(ptr4));
    rr_arbiter #(.LOGN(2), .MAXHOLD(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .bus(if0), .dbg_state_o(st0), .dbg_ptr_o(ptr0));

    // Clock generation
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to just after the next rising edge; outputs are sampled there and inputs changed there.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        if8.di_req = '0;
        if4.di_req = '0;
        if0.di_req = '0;
        #12;
        checks++; if (if8.do_gnt !== 4'b0000) begin errors++; $display("FAIL reset_gnt got=%b exp=0000", if8.do_gnt); end
        checks++; if (if8.do_gnt_id !== 2'd0) begin errors++; $display("FAIL reset_id got=%0d exp=0", if8.do_gnt_id); end
        checks++; if (if8.co_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", if8.co_busy); end
        checks++; if (if8.co_preempt !== 1'b0) begin errors++; $display("FAIL reset_preempt got=%b exp=0", if8.co_preempt); end
        checks++; if (ptr8 !== 2'd0) begin errors++; $display("FAIL reset_ptr got=%0d exp=0", ptr8); end
        #1 rst_n = 1'b1;
        tick();
    endtask

    task automatic test_rotation();
        int order [5] = '{0, 1, 2, 3, 0};
        logic [3:0] exp_g;
        if8.di_req = 4'b1111;
        for (int n = 0; n < 5; n++) begin
            exp_g = 4'b0001 << order[n];
            tick();
            checks++; if (if8.do_gnt !== exp_g || if8.do_gnt_id !== 2'(order[n]))
                begin errors++; $display("FAIL rot_grant%0d got=%b/%0d exp=%b/%0d", n, if8.do_gnt, if8.do_gnt_id, exp_g, order[n]); end
            tick();
            checks++; if (if8.do_gnt !== exp_g) begin errors++; $display("FAIL rot_hold%0d got=%b exp=%b", n, if8.do_gnt, exp_g); end
            if8.di_req = 4'b1111 & ~exp_g;
            tick();
            checks++; if (if8.do_gnt !== 4'b0000 || if8.co_busy !== 1'b0)
                begin errors++; $display("FAIL rot_idle%0d got=%b busy=%b exp=0000 busy=0", n, if8.do_gnt, if8.co_busy); end
            if8.di_req = (n == 4) ? 4'b0000 : 4'b1111;
        end
        tick();
    endtask

    task automatic test_single();
        if8.di_req = 4'b0100;
        for (int c = 0; c < 3; c++) begin
            tick();
            checks++; if (if8.do_gnt !== 4'b0100 || if8.do_gnt_id !== 2'd2)
                begin errors++; $display("FAIL single_c%0d got=%b/%0d exp=0100/2", c, if8.do_gnt, if8.do_gnt_id); end
        end
        if8.di_req = 4'b0000;
        tick();
        checks++; if (if8.do_gnt !== 4'b0000 || if8.co_busy !== 1'b0)
            begin errors++; $display("FAIL single_release got=%b busy=%b exp=0000 busy=0", if8.do_gnt, if8.co_busy); end
        checks++; if (if8.do_gnt_id !== 2'd2) begin errors++; $display("FAIL single_id_hold got=%0d exp=2", if8.do_gnt_id); end
        checks++; if (ptr8 !== 2'd3) begin errors++; $display("FAIL single_ptr got=%0d exp=3", ptr8); end
    endtask

    task automatic test_wrap_priority();
        if8.di_req = 4'b0011;
        tick();
        checks++; if (if8.do_gnt !== 4'b0001 || if8.do_gnt_id !== 2'd0)
            begin errors++; $display("FAIL wrap_prio got=%b/%0d exp=0001/0", if8.do_gnt, if8.do_gnt_id); end
        if8.di_req = 4'b0000;
        tick();
    endtask

    task automatic test_preempt();
        if4.di_req = 4'b0010;
        tick();
        checks++; if (if4.do_gnt !== 4'b0010) begin errors++; $display("FAIL pre_c1 got=%b exp=0010", if4.do_gnt); end
        tick();
        checks++; if (if4.do_gnt !== 4'b0010) begin errors++; $display("FAIL pre_c2 got=%b exp=0010", if4.do_gnt); end
        if4.di_req = 4'b1010;
        tick();
        checks++; if (if4.do_gnt !== 4'b0010) begin errors++; $display("FAIL pre_c3 got=%b exp=0010", if4.do_gnt); end
        tick();
        checks++; if (if4.do_gnt !== 4'b0010 || if4.co_preempt !== 1'b0)
            begin errors++; $display("FAIL pre_c4 got=%b pre=%b exp=0010 pre=0", if4.do_gnt, if4.co_preempt); end
        tick();
        checks++; if (if4.do_gnt !== 4'b0000 || if4.co_preempt !== 1'b1)
            begin errors++; $display("FAIL pre_revoke got=%b pre=%b exp=0000 pre=1", if4.do_gnt, if4.co_preempt); end
        tick();
        checks++; if (if4.do_gnt !== 4'b1000 || if4.co_preempt !== 1'b0)
            begin errors++; $display("FAIL pre_next got=%b pre=%b exp=1000 pre=0", if4.do_gnt, if4.co_preempt); end
        // Owner 3 drops its request exactly on its timeout edge while 1 waits.
        tick();
        tick();
        tick();
        checks++; if (if4.do_gnt !== 4'b1000) begin errors++; $display("FAIL sim_c4 got=%b exp=1000", if4.do_gnt); end
        if4.di_req = 4'b0010;
        tick();
        checks++; if (if4.do_gnt !== 4'b0000 || if4.co_preempt !== 1'b0)
            begin errors++; $display("FAIL sim_release got=%b pre=%b exp=0000 pre=0", if4.do_gnt, if4.co_preempt); end
        tick();
        checks++; if (if4.do_gnt !== 4'b0010 || if4.do_gnt_id !== 2'd1)
            begin errors++; $display("FAIL sim_regrant got=%b/%0d exp=0010/1", if4.do_gnt, if4.do_gnt_id); end
        if4.di_req = 4'b0000;
        tick();
    endtask

    task automatic test_no_contention();
        int bad;
        if4.di_req = 4'b0100;
        bad = 0;
        for (int c = 0; c < 20; c++) begin
            tick();
            checks++; if (if4.do_gnt !== 4'b0100 || if4.co_preempt !== 1'b0)
                begin errors++; bad++; if (bad < 4) $display("FAIL lone_c%0d got=%b pre=%b exp=0100 pre=0", c, if4.do_gnt, if4.co_preempt); end
        end
        if4.di_req = 4'b0000;
        if0.di_req = 4'b0001;
        tick();
        checks++; if (if0.do_gnt !== 4'b0001) begin errors++; $display("FAIL nolimit_grant got=%b exp=0001", if0.do_gnt); end
        if0.di_req = 4'b1111;
        for (int c = 0; c < 20; c++) begin
            tick();
            checks++; if (if0.do_gnt !== 4'b0001 || if0.co_preempt !== 1'b0)
                begin errors++; bad++; if (bad < 8) $display("FAIL nolimit_c%0d got=%b pre=%b exp=0001 pre=0", c, if0.do_gnt, if0.co_preempt); end
        end
        if0.di_req = 4'b0000;
        tick();
        checks++; if (if0.do_gnt !== 4'b0000) begin errors++; $display("FAIL nolimit_release got=%b exp=0000", if0.do_gnt); end
    endtask

    task automatic test_async_reset();
        if8.di_req = 4'b0010;
        tick();
        checks++; if (if8.do_gnt !== 4'b0010) begin errors++; $display("FAIL ar_pre got=%b exp=0010", if8.do_gnt); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (if8.do_gnt !== 4'b0000 || if8.do_gnt_id !== 2'd0 || if8.co_busy !== 1'b0 || if8.co_preempt !== 1'b0)
            begin errors++; $display("FAIL ar_drop got=%b/%0d busy=%b pre=%b exp=0000/0 busy=0 pre=0", if8.do_gnt, if8.do_gnt_id, if8.co_busy, if8.co_preempt); end
        checks++; if (ptr8 !== 2'd0) begin errors++; $display("FAIL ar_ptr got=%0d exp=0", ptr8); end
        if8.di_req = 4'b1111;
        #1 rst_n = 1'b1;
        tick();
        checks++; if (if8.do_gnt !== 4'b0001 || if8.do_gnt_id !== 2'd0)
            begin errors++; $display("FAIL ar_regrant got=%b/%0d exp=0001/0", if8.do_gnt, if8.do_gnt_id); end
        if8.di_req = 4'b0000;
        tick();
    endtask

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_rotation();
        test_single();
        test_wrap_priority();
        test_preempt();
        test_no_contention();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/rr_arbiter.md
# rr_arbiter

Round-robin arbiter that shares one datapath resource (the comparator / priority-coder unit) among 2**LOGN requesters. Grants are registered and one-hot, and an owner keeps its grant for as long as it holds its request. An optional hold limit preempts an owner that monopolises the resource while others wait. The block sits between the requesting units and the shared resource and drives that resource's operand-select mux with do_gnt_id.

## Interface
- LOGN, 2: log2 of requester count; N = 2**LOGN; LOGN >= 1.
- MAXHOLD, 8: maximum grant length in cycles while another requester waits; 0 disables preemption.

- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- di_req  in  N  level request per requester; bit i high = requester i wants or keeps the resource.
- do_gnt  out  N  registered one-hot grant; all zero when idle.
- do_gnt_id  out  LOGN  binary index of the current owner; holds the last owner when idle.
- co_busy  out  1  high while any grant is active (equals |do_gnt).
- co_preempt  out  1  one-cycle pulse in the first cycle after a grant is revoked by timeout.

## Operation
- Two states:
  - IDLE: do_gnt == 0.
  - BUSY: exactly one do_gnt bit is high.
- Round-robin pointer ptr (LOGN bits, reset 0) marks the highest-priority index.
  - Search order: ptr, ptr+1, …, N-1, 0, …, ptr-1 (mod N wrap-around).
  - The first asserted di_req bit in that order wins.
- IDLE -> BUSY: on an edge where di_req != 0.
  - Winner w gets do_gnt = 1<<w and do_gnt_id = w.
  - ptr <= w+1 mod N.
  - hold_cnt <= 0.
- BUSY, owner o:
  - Release: di_req[o] sampled low -> BUSY -> IDLE; do_gnt <= 0, co_preempt stays 0.
  - Preempt (MAXHOLD > 0): di_req[o] high, hold_cnt == MAXHOLD-1 and (di_req & ~do_gnt) != 0 -> BUSY -> IDLE; do_gnt <= 0, co_preempt <= 1.
  - Otherwise: stay BUSY; hold_cnt increments and saturates at MAXHOLD-1.
- ptr already points past o, so after a preemption the next arbitration favours the waiting requesters.
- Requests arriving during BUSY are never granted directly. Every ownership change passes through at least one IDLE cycle with do_gnt == 0 (bus turnaround).
- Simultaneous release and timeout in the same cycle: treated as a normal release, co_preempt = 0.
- No waiting requester when hold_cnt reaches MAXHOLD-1: the grant continues and hold_cnt holds at MAXHOLD-1. If a competitor appears later, preemption happens on the next edge.
- MAXHOLD = 0: hold_cnt is unused; the owner keeps its grant until it drops di_req.
- hold_cnt width: $clog2(MAXHOLD+1), minimum 1 bit.

## Timing
- Reset (rst_n low, asynchronous): do_gnt = 0, do_gnt_id = 0, co_busy = 0, co_preempt = 0, ptr = 0, hold_cnt = 0, state IDLE.
- Reset asserted mid-grant drops the grant immediately, without waiting for a clock edge.
- Grant latency: di_req sampled high at edge k in IDLE -> do_gnt valid after edge k; the owner may use the resource from cycle k+1 onward.
- Release latency: owner drops di_req before edge k -> do_gnt = 0 after edge k. The earliest new grant appears after edge k+1.
- Maximum grant length under contention: MAXHOLD cycles. co_preempt is high for exactly the one cycle following the revoking edge.
- All outputs come directly from registers; there is no combinational path from di_req to any output.

## Test plan
- Reset and single requester (LOGN=2, MAXHOLD=8): hold rst_n=0, then release. Drive di_req=0100 for 3 cycles, then 0000.
  - Required: do_gnt=0100 and do_gnt_id=2 one edge after the request, for 3 cycles; then do_gnt=0 and co_busy=0.
  - Next arbitration starts from ptr=3.
- Rotation with wrap: di_req=1111 and each owner drops its request for one cycle after 2 cycles of grant.
  - Required grant order: 0, 1, 2, 3, 0, with exactly one idle cycle between grants.
- Wrap priority: with ptr=3 (after granting 2), drive di_req=0011.
  - Required: requester 0 is granted, not 1.
- Preemption (MAXHOLD=4): requester 1 holds di_req; requester 3 raises its request in the second grant cycle.
  - Required: the grant to 1 lasts exactly 4 cycles, then one idle cycle with co_preempt=1, then do_gnt=1000.
  - Also cover simultaneous release and timeout: co_preempt stays 0.
- No contention / disabled limit: a lone owner under MAXHOLD=4 held for 20 cycles keeps its grant with no co_preempt. With MAXHOLD=0 and competitors waiting, the owner also keeps its grant for 20 cycles.
- Asynchronous reset mid-grant: pull rst_n low between edges while do_gnt=0010.
  - Required: all outputs drop to 0 immediately, without a clock edge.
  - After release, ptr=0 and di_req=1111 grants requester 0.
